mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage initiator between EXMEM and the data memory (stalling mem / cache).
//  Issues one Rd/Wr per EXMEM memory op and waits for Done.
//  Freezes the pipeline while the access is outstanding.
//  Drives mem_read_data / data_mem_stall / data_mem_done / data_mem_err into MEMWB.
// PARAMETERS
//  DATA_W   16  data width
//  ADDR_W   16  address width
//  TIMEOUT  32  max WAIT cycles before the access is declared failed (>=2)
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous active-high reset
//  MemRead_EXMEM   in   1       load in EXMEM
//  MemWrite_EXMEM  in   1       store in EXMEM
//  Halt_EXMEM      in   1       HALT in EXMEM
//  ALU_Out_EXMEM   in   ADDR_W  access address
//  wdata_EXMEM     in   DATA_W  store data
//  mem_stall       in   1       memory busy, cannot accept a request
//  mem_done        in   1       access complete; read data valid this cycle
//  mem_err         in   1       memory error, sampled with mem_done or alone
//  mem_data_out    in   DATA_W  read data from memory
//  mem_rd          out  1       read strobe
//  mem_wr          out  1       write strobe
//  mem_addr        out  ADDR_W  = ALU_Out_EXMEM
//  mem_wdata       out  DATA_W  = wdata_EXMEM
//  mem_createdump  out  1       Halt_EXMEM & state==IDLE
//  stall_out       out  1       freeze PC/IFID/IDEX/EXMEM; deassert MEMWB en
//  mem_read_data   out  DATA_W  registered read data
//  data_mem_stall  out  1       = stall_out
//  data_mem_done   out  1       1 in RESP only
//  data_mem_err    out  1       error for the completing op, valid in RESP
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0, mem_read_data=0, err=0; all 1-bit outputs 0.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE, no op (rd=wr=0): no stall, stay.
//  IDLE, op with mem_stall=1: stall_out=1, no strobe, stay.
//  IDLE, op with mem_stall=0: strobe mem_rd/mem_wr for exactly 1 cycle, stall_out=1 -> WAIT.
//  IDLE, rd&wr both set: no strobe, err=1, stall_out=1 -> RESP.
//  WAIT: strobes 0, stall_out=1, counter++.
//  WAIT on mem_done: latch mem_data_out (reads only; stores latch 0), err<=mem_err -> RESP.
//  WAIT on mem_err without done: err=1, data=0 -> RESP.
//  WAIT when counter==TIMEOUT-1 and no done: err=1, data=0 -> RESP.
//  RESP: stall_out=0, data_mem_done=1 -> IDLE. EXMEM advances; MEMWB captures outputs.
//  RESP: counter/err cleared on exit.
//  Latency: op enters EXMEM at t, mem_done at t+k (k>=1); stall_out high t..t+k.
//  Latency cont.: RESP at t+k+1. Minimum 2 stall cycles.
//  mem_done/mem_err in IDLE or RESP are ignored (no outstanding access).
//  Counter width clog2(TIMEOUT); never wraps: saturates, exits at TIMEOUT-1.
//  Reset mid-WAIT: access abandoned, strobes drop immediately, late mem_done ignored.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: op with ALU_Out_EXMEM[0]==1 is not issued.
//    Misaligned op: err=1, data=0, IDLE -> RESP (1 stall cycle).
//  MEM_ALIGN_CHECK_EN undefined: address passed unchanged; no alignment error ever raised.
// TESTING
//  Load at 0x0010, mem_done 3 cyc after strobe, data 0xBEEF:
//    mem_rd 1 cyc; stall_out 4 cyc.
//    RESP: mem_read_data=0xBEEF, data_mem_done=1, err=0.
//  Store 0x1234 to 0x0020, mem_stall=1 for 2 cyc:
//    no mem_wr during stall; mem_wr then for 1 cyc with mem_wdata=0x1234.
//  Load, memory never responds (TIMEOUT=32):
//    RESP after 32 WAIT cyc, data_mem_err=1, mem_read_data=0.
//  MemRead=MemWrite=1: no strobes; next cycle RESP with data_mem_err=1.
//  rst pulsed 2 cyc into WAIT, then mem_done:
//    state IDLE, outputs 0; mem_done ignored, no data_mem_done.
//  With MEM_ALIGN_CHECK_EN, load at 0x0011: no mem_rd, RESP err=1.
//    Same case without the macro: normal load at 0x0011.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : Memory-stage initiator between EXMEM and a stalling data memory.
//            Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address rejection).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_EXMEM,
    input  logic              MemWrite_EXMEM,
    input  logic              Halt_EXMEM,
    input  logic [ADDR_W-1:0] ALU_Out_EXMEM,
    input  logic [DATA_W-1:0] wdata_EXMEM,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic              mem_err,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_createdump,
    output logic              stall_out,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              data_mem_stall,
    output logic              data_mem_done,
    output logic              data_mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              is_rd_q, is_rd_d;

    logic w_op;
    logic w_conflict;
    logic w_misalign;
    logic w_rd;
    logic w_wr;
    logic w_stall;

    assign w_op       = MemRead_EXMEM | MemWrite_EXMEM;
    assign w_conflict = MemRead_EXMEM & MemWrite_EXMEM;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_op & ALU_Out_EXMEM[0];
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            is_rd_q <= is_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        is_rd_d = is_rd_q;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_op) begin
                    w_stall = 1'b1;
                    // Illegal ops complete immediately with an error, never reaching memory
                    if (w_conflict || w_misalign) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (!mem_stall) begin
                        w_rd    = MemRead_EXMEM;
                        w_wr    = MemWrite_EXMEM;
                        is_rd_d = MemRead_EXMEM;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_done) begin
                    rdata_d = is_rd_q ? mem_data_out : '0;
                    err_d   = mem_err;
                    state_d = S_RESP;
                end else if (mem_err || (cnt_q == C_CNT_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held so an abandoned access drops at once
    assign mem_rd         = w_rd & ~rst;
    assign mem_wr         = w_wr & ~rst;
    assign stall_out      = w_stall & ~rst;
    assign mem_createdump = Halt_EXMEM & (state_q == S_IDLE) & ~rst;
    assign data_mem_stall = stall_out;
    assign data_mem_done  = (state_q == S_RESP);
    assign data_mem_err   = err_q;
    assign mem_read_data  = rdata_q;
    assign mem_addr       = ALU_Out_EXMEM;
    assign mem_wdata      = wdata_EXMEM;

endmodule

`default_nettype wire
